// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_pkg
// Description : Shared fixed-point definitions for the narrowing stages:
//               rounding-mode enumeration and signed saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

    // Rounding applied when dropping fraction bits.
    typedef enum logic [0:0] {
        ROUND_TRUNCATE  = 1'b0,  // floor (arithmetic shift)
        ROUND_HALF_EVEN = 1'b1   // round to nearest, ties to even
    } round_mode_e;

    // Largest value of a signed (ibits+fbits)-bit word.
    function automatic logic signed [63:0] sat_max(input int ibits, input int fbits);
        return (64'sd1 <<< (ibits + fbits - 1)) - 64'sd1;
    endfunction

    // Smallest value of a signed (ibits+fbits)-bit word.
    function automatic logic signed [63:0] sat_min(input int ibits, input int fbits);
        return -(64'sd1 <<< (ibits + fbits - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_narrow.sv
`default_nettype none
// ============================================================================
// Module      : fp_narrow
// Description : Two-stage narrowing pipeline after the FMA. Rounds the
//               double-width product to the single fraction width, saturates
//               to the single format, passes the tag through, and counts
//               saturated results (sticky at all-ones).
// Revision    : 1.0 - initial release
// ============================================================================
module fp_narrow
    import fixed_point_pkg::*;
#(
    parameter int          IBITS      = 12,
    parameter int          FBITS      = 20,
    parameter int          ID_BITS    = 8,
    parameter round_mode_e ROUND_MODE = ROUND_HALF_EVEN,
    parameter int          COUNT_BITS = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2*(IBITS+FBITS):0]     a,
    input  logic [ID_BITS-1:0]           iid,
    input  logic                         ivalid,
    output logic                         iacknowledge,
    output logic [IBITS+FBITS-1:0]       r,
    output logic [ID_BITS-1:0]           oid,
    output logic                         saturated,
    output logic                         ovalid,
    input  logic                         oacknowledge,
    output logic [COUNT_BITS-1:0]        sat_count
);

    // Input width and single-format width.
    localparam int c_width  = 2 * (IBITS + FBITS) + 1;
    localparam int c_single = IBITS + FBITS;

    // One guard bit above the input keeps the rounding add from overflowing.
    typedef logic signed [c_width:0]  wide_t;
    typedef logic [c_single-1:0]      single_t;

    typedef struct packed {
        logic               valid;
        logic [ID_BITS-1:0] id;
        wide_t              value;
    } stage_t;

    localparam wide_t c_one  = wide_t'(1);
    // 2^(FBITS-1)-1: with the kept LSB added, exact ties round toward even.
    localparam wide_t c_bias = (c_one <<< (FBITS - 1)) - c_one;
    localparam wide_t c_max  = wide_t'(sat_max(IBITS, FBITS));
    localparam wide_t c_min  = wide_t'(sat_min(IBITS, FBITS));

    logic [1:0]              r_rst_sync;
    stage_t                  r_s1;
    single_t                 r_r;
    logic [ID_BITS-1:0]      r_oid;
    logic                    r_sat;
    logic                    r_ovalid;
    logic [COUNT_BITS-1:0]   r_count;

    logic                    w_rst_n;
    logic                    w_advance;
    wide_t                   w_wide;
    wide_t                   w_sum;
    wide_t                   w_round;
    wide_t                   w_s1_value;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    single_t                 w_clipped;

    assign w_rst_n      = r_rst_sync[1];
    assign w_advance    = !r_ovalid || oacknowledge;
    assign iacknowledge = w_advance;

    assign r         = r_r;
    assign oid       = r_oid;
    assign saturated = r_sat;
    assign ovalid    = r_ovalid;
    assign sat_count = r_count;

    // Reset asserts immediately, releases on the second clock edge after deassertion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Stage 1 rounding: sign-extend, optionally bias, then drop FBITS fraction bits.
    always_comb begin
        w_wide  = {a[c_width-1], a};
        w_sum   = w_wide + c_bias + wide_t'(a[FBITS]);
        w_round = (ROUND_MODE == ROUND_HALF_EVEN) ? (w_sum >>> FBITS) : (w_wide >>> FBITS);
    end

    // Stage 2 saturation: clip the rounded value to the single-format range.
    always_comb begin
        w_s1_value = r_s1.value;
        w_sat_hi   = (w_s1_value > c_max);
        w_sat_lo   = (w_s1_value < c_min);
        if (w_sat_hi) begin
            w_clipped = c_max[c_single-1:0];
        end else if (w_sat_lo) begin
            w_clipped = c_min[c_single-1:0];
        end else begin
            w_clipped = w_s1_value[c_single-1:0];
        end
    end

    // Both pipeline stages move together on advance; the counter sticks at all-ones.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_s1     <= '0;
            r_r      <= '0;
            r_oid    <= '0;
            r_sat    <= 1'b0;
            r_ovalid <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_advance) begin
                r_s1.valid <= ivalid;
                r_s1.id    <= iid;
                r_s1.value <= w_round;
                r_ovalid   <= r_s1.valid;
                r_oid      <= r_s1.id;
                r_r        <= w_clipped;
                r_sat      <= r_s1.valid && (w_sat_hi || w_sat_lo);
            end
            if (r_ovalid && oacknowledge && r_sat && (r_count != '1)) begin
                r_count <= r_count + COUNT_BITS'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_narrow.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_narrow
// Description : Self-checking bench for fp_narrow. Three instances (default,
//               truncating, 2-bit counter) share one stimulus stream; a
//               scoreboard with an arithmetic reference model checks every
//               output transfer, plus directed vectors and reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_narrow;
    import fixed_point_pkg::*;

    localparam int c_ib = 12;
    localparam int c_fb = 20;
    localparam int c_w  = 2 * (c_ib + c_fb) + 1;
    localparam int c_n  = c_ib + c_fb;

    typedef logic signed [95:0] big_t;

    typedef struct {
        logic [c_w-1:0] a;
        logic [7:0]     id;
        logic [c_n-1:0] r_he;
        logic           s_he;
        logic [c_n-1:0] r_tr;
    } vec_t;

    typedef struct {
        logic [7:0]     id;
        logic [c_n-1:0] m_he;
        logic           ms_he;
        logic [c_n-1:0] m_tr;
        logic           ms_tr;
        bit             has_tab;
        logic [c_n-1:0] t_he;
        logic           ts_he;
        logic [c_n-1:0] t_tr;
        int             acc;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset;
    logic [c_w-1:0] a;
    logic [7:0]     iid;
    logic           ivalid;
    logic           oack;
    logic           iack, iack_tr, iack_c2;
    logic [c_n-1:0] r, r_tr, r_c2;
    logic [7:0]     oid, oid_tr, oid_c2;
    logic           sat, sat_tr, sat_c2;
    logic           ovalid, ovalid_tr, ovalid_c2;
    logic [15:0]    cnt, cnt_tr;
    logic [1:0]     cnt_c2;

    always #5 clock = ~clock;

    fp_narrow u_dut (
        .clock(clock), .reset(reset), .a(a), .iid(iid), .ivalid(ivalid),
        .iacknowledge(iack), .r(r), .oid(oid), .saturated(sat), .ovalid(ovalid),
        .oacknowledge(oack), .sat_count(cnt)
    );

    fp_narrow #(.ROUND_MODE(ROUND_TRUNCATE)) u_trunc (
        .clock(clock), .reset(reset), .a(a), .iid(iid), .ivalid(ivalid),
        .iacknowledge(iack_tr), .r(r_tr), .oid(oid_tr), .saturated(sat_tr), .ovalid(ovalid_tr),
        .oacknowledge(oack), .sat_count(cnt_tr)
    );

    fp_narrow #(.COUNT_BITS(2)) u_cnt2 (
        .clock(clock), .reset(reset), .a(a), .iid(iid), .ivalid(ivalid),
        .iacknowledge(iack_c2), .r(r_c2), .oid(oid_c2), .saturated(sat_c2), .ovalid(ovalid_c2),
        .oacknowledge(oack), .sat_count(cnt_c2)
    );

    // Reference: exact floor division, then round-half-even on the remainder, then clamp.
    function automatic void model(input logic [c_w-1:0] av, input bit he,
                                  output logic [c_n-1:0] rv, output logic sv);
        big_t v, d, q, rem, hi, lo;
        v   = {{(96 - c_w){av[c_w-1]}}, av};
        d   = big_t'(1) <<< c_fb;
        q   = v / d;
        rem = v - q * d;
        if (rem < big_t'(0)) begin
            q   = q - big_t'(1);
            rem = rem + d;
        end
        if (he && ((rem > d / big_t'(2)) || ((rem == d / big_t'(2)) && q[0]))) q = q + big_t'(1);
        hi = (big_t'(1) <<< (c_n - 1)) - big_t'(1);
        lo = -(big_t'(1) <<< (c_n - 1));
        sv = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        else if (q < lo) q = lo;
        rv = q[c_n-1:0];
    endfunction

    function automatic logic [c_w-1:0] rand_a();
        big_t v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom, $urandom};
            1: begin
                v = (big_t'(1) <<< 51) + big_t'($urandom_range(0, 2097152)) - (big_t'(1) <<< 20);
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            2: begin
                v = (big_t'($urandom_range(0, 255)) <<< 20) + (big_t'(1) <<< 19);
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = big_t'($signed({$urandom, $urandom})) >>> 12;
        endcase
        return v[c_w-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard / monitor
    // ------------------------------------------------------------------
    int   n_chk = 0;
    int   n_fail = 0;
    int   mcyc = 0;
    int   appear = 0;
    int   exp_cnt = 0;
    int   exp_cnt_tr = 0;
    bit   prev_ov = 1'b0;
    bit   prev_x = 1'b0;
    bit   end_done = 1'b0;
    logic end_check = 1'b0;
    exp_t sb[$];

    bit             cur_tab = 1'b0;
    logic [c_n-1:0] cur_t_he = '0;
    logic           cur_ts_he = 1'b0;
    logic [c_n-1:0] cur_t_tr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(negedge clock or negedge reset) begin : monitor
        exp_t e;
        if (reset !== 1'b1) begin
            sb.delete();
            exp_cnt    = 0;
            exp_cnt_tr = 0;
            prev_ov    = 1'b0;
            prev_x     = 1'b0;
            #1;
            chk("rst_ovalid",  64'(ovalid), 64'(0));
            chk("rst_r",       64'(r),      64'(0));
            chk("rst_oid",     64'(oid),    64'(0));
            chk("rst_sat",     64'(sat),    64'(0));
            chk("rst_count",   64'(cnt),    64'(0));
            chk("rst_count2",  64'(cnt_c2), 64'(0));
            chk("rst_iack",    64'(iack),   64'(1));
        end else begin
            mcyc++;
            chk("iack_rule",    64'(iack),    64'(!ovalid || oack));
            chk("iack_rule_tr", 64'(iack_tr), 64'(!ovalid_tr || oack));
            chk("iack_rule_c2", 64'(iack_c2), 64'(!ovalid_c2 || oack));
            if (ovalid && (!prev_ov || prev_x)) appear = mcyc;
            if (ovalid && oack) begin
                chk("output_expected", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("oid",       64'(oid),       64'(e.id));
                    chk("r",         64'(r),         64'(e.m_he));
                    chk("saturated", 64'(sat),       64'(e.ms_he));
                    chk("ovalid_tr", 64'(ovalid_tr), 64'(1));
                    chk("oid_tr",    64'(oid_tr),    64'(e.id));
                    chk("r_tr",      64'(r_tr),      64'(e.m_tr));
                    chk("sat_tr",    64'(sat_tr),    64'(e.ms_tr));
                    chk("ovalid_c2", 64'(ovalid_c2), 64'(1));
                    chk("oid_c2",    64'(oid_c2),    64'(e.id));
                    chk("r_c2",      64'(r_c2),      64'(e.m_he));
                    chk("sat_c2",    64'(sat_c2),    64'(e.ms_he));
                    chk("sat_count",    64'(cnt),    64'(exp_cnt));
                    chk("sat_count_tr", 64'(cnt_tr), 64'(exp_cnt_tr));
                    chk("sat_count_c2", 64'(cnt_c2), 64'((exp_cnt > 3) ? 3 : exp_cnt));
                    if (e.has_tab) begin
                        chk("vec_r",    64'(r),    64'(e.t_he));
                        chk("vec_sat",  64'(sat),  64'(e.ts_he));
                        chk("vec_r_tr", 64'(r_tr), 64'(e.t_tr));
                        chk("latency",  64'(appear - e.acc), 64'(2));
                    end
                    if (e.ms_he) exp_cnt++;
                    if (e.ms_tr) exp_cnt_tr++;
                end
            end
            prev_ov = ovalid;
            prev_x  = ovalid && oack;
            if (ivalid && iack) begin
                e.id = iid;
                model(a, 1'b1, e.m_he, e.ms_he);
                model(a, 1'b0, e.m_tr, e.ms_tr);
                e.has_tab = cur_tab;
                e.t_he    = cur_t_he;
                e.ts_he   = cur_ts_he;
                e.t_tr    = cur_t_tr;
                e.acc     = mcyc;
                sb.push_back(e);
            end
            if (end_check && !end_done) begin
                chk("drain_empty", 64'(sb.size()), 64'(0));
                end_done = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int cyc = 0;
    int stall_lo = 0;
    int stall_hi = -1;
    bit rand_oack = 1'b0;
    bit hold_stall = 1'b0;
    vec_t vecs[9];

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (hold_stall) oack = 1'b0;
        else if (rand_oack) oack = ($urandom_range(0, 3) != 0);
        else oack = !((cyc >= stall_lo) && (cyc <= stall_hi));
    endtask

    task automatic send(input logic [c_w-1:0] av, input logic [7:0] idv, input bit tab,
                        input logic [c_n-1:0] the, input logic tse, input logic [c_n-1:0] ttr);
        bit acc;
        int guard;
        guard     = 0;
        a         = av;
        iid       = idv;
        ivalid    = 1'b1;
        cur_tab   = tab;
        cur_t_he  = the;
        cur_ts_he = tse;
        cur_t_tr  = ttr;
        do begin
            @(negedge clock);
            acc = iack;
            tick();
            guard++;
            if (!acc && guard > 200) begin
                $display("FAIL send_timeout: id %0h not accepted after %0d cycles, expected acceptance", idv, guard);
                $fatal(1, "input never accepted");
            end
        end while (!acc);
    endtask

    task automatic idle();
        ivalid  = 1'b0;
        cur_tab = 1'b0;
    endtask

    initial begin
        vecs[0] = '{65'h180_0000_0000, 8'h11, 32'h0018_0000, 1'b0, 32'h0018_0000};
        vecs[1] = '{65'h18_0000, 8'h21, 32'h0000_0002, 1'b0, 32'h0000_0001};
        vecs[2] = '{65'h08_0000, 8'h22, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[3] = '{-65'h08_0000, 8'h23, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
        vecs[4] = '{-65'h18_0000, 8'h24, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE};
        vecs[5] = '{65'd1 << 51, 8'h31, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF};
        vecs[6] = '{-(65'd2049 << 40), 8'h32, 32'h8000_0000, 1'b1, 32'h8000_0000};
        vecs[7] = '{-(65'd1 << 51), 8'h33, 32'h8000_0000, 1'b0, 32'h8000_0000};
        vecs[8] = '{(65'h7FFF_FFFF << 20) + 65'h8_0000, 8'h34, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF};

        a      = '0;
        iid    = '0;
        ivalid = 1'b0;
        oack   = 1'b1;
        reset  = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();

        // Directed vectors: rounding ties, saturation limits, latency.
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].a, vecs[i].id, 1'b1, vecs[i].r_he, vecs[i].s_he, vecs[i].r_tr);
        end
        idle();
        repeat (4) tick();

        // Backpressure: ids 1..6 back to back, output stalled for cycles 3-5.
        stall_lo = cyc + 3;
        stall_hi = cyc + 5;
        for (int i = 1; i <= 6; i++) begin
            send(rand_a(), 8'(i), 1'b0, '0, 1'b0, '0);
        end
        idle();
        repeat (6) tick();

        // Reset while two items are in flight and the output is stalled.
        hold_stall = 1'b1;
        oack       = 1'b0;
        send(rand_a(), 8'hA1, 1'b0, '0, 1'b0, '0);
        send(rand_a(), 8'hA2, 1'b0, '0, 1'b0, '0);
        idle();
        tick();
        tick();
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        hold_stall = 1'b0;
        repeat (4) tick();
        send(vecs[0].a, 8'h5A, 1'b1, vecs[0].r_he, vecs[0].s_he, vecs[0].r_tr);

        // Five saturating results: the 2-bit counter must stick at 3.
        for (int i = 0; i < 5; i++) begin
            send((65'd1 << 51) + 65'(i), 8'(8'hC0 + i), 1'b0, '0, 1'b0, '0);
        end
        send(65'h1, 8'hCF, 1'b0, '0, 1'b0, '0);
        idle();
        repeat (4) tick();

        // Random data with random gaps and random output stalls.
        rand_oack = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_a(), 8'($urandom_range(0, 255)), 1'b0, '0, 1'b0, '0);
            if ($urandom_range(0, 4) == 0) begin
                idle();
                tick();
            end
        end
        idle();
        rand_oack = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        end_check = 1'b1;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
